// File: rtl/dp_pkg.sv
// Shared constants for the execute-stage datapath: ALU op codes, operand
// select encodings and status-register bit positions.
package dp_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOT  = 4'h5;
   localparam logic [3:0] ALU_NOT2 = 4'h6;
   localparam logic [3:0] ALU_SHL  = 4'h7;
   localparam logic [3:0] ALU_SHR  = 4'h8;

   localparam logic [1:0] SELA_A    = 2'b00;
   localparam logic [1:0] SELA_B    = 2'b01;
   localparam logic [1:0] SELA_ZERO = 2'b10;
   localparam logic [1:0] SELA_ONE  = 2'b11;

   localparam logic [1:0] SELB_B    = 2'b00;
   localparam logic [1:0] SELB_A    = 2'b01;
   localparam logic [1:0] SELB_K    = 2'b10;
   localparam logic [1:0] SELB_ZERO = 2'b11;

   localparam int ST_Z = 0;
   localparam int ST_N = 1;
   localparam int ST_C = 2;
   localparam int ST_V = 3;

   // Packed in status-register order {V,C,N,Z}.
   typedef struct packed {
      logic v;
      logic c;
      logic n;
      logic z;
   } dp_flags_t;

endpackage

// File: rtl/dp_if.sv
// Decoder-to-datapath bundle: decoded strobes and literal in, PC/flags/debug
// registers and the data-memory write port out. The master side is the
// decoder / memory environment, the slave side is datapath_core.
interface dp_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   import dp_pkg::*;

   logic          LA;
   logic          LB;
   logic          LP;
   logic          W;
   logic [1:0]    selA;
   logic [1:0]    selB;
   logic          selData;
   logic [3:0]    alu_op;
   logic [DW-1:0] K;
   logic [AW-1:0] pc;
   logic [3:0]    status;
   logic [DW-1:0] reg_a;
   logic [DW-1:0] reg_b;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_wvalid;
   logic          mem_wready;

   modport master (
      output LA, LB, LP, W, selA, selB, selData, alu_op, K, mem_wready,
      input  pc, status, reg_a, reg_b, mem_addr, mem_wdata, mem_wvalid
   );

   modport slave (
      input  LA, LB, LP, W, selA, selB, selData, alu_op, K, mem_wready,
      output pc, status, reg_a, reg_b, mem_addr, mem_wdata, mem_wvalid
   );

endinterface

// File: rtl/dp_alu.sv
// Combinational ALU: (x, y, op) -> result plus Z/N/C/V flags.
// Unlisted op codes give a zero result with C=V=0.
module dp_alu
   import dp_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   input  logic [3:0]    op,
   output logic [DW-1:0] res,
   output logic          z,
   output logic          n,
   output logic          c,
   output logic          v
);

   logic [DW:0] wide;

   // Function select; carry/borrow taken from the extra bit of a DW+1 wide op.
   always_comb begin
      wide = '0;
      res  = '0;
      c    = 1'b0;
      v    = 1'b0;
      case (op)
         ALU_ADD: begin
            wide = {1'b0, x} + {1'b0, y};
            res  = wide[DW-1:0];
            c    = wide[DW];
            v    = (x[DW-1] == y[DW-1]) && (res[DW-1] != x[DW-1]);
         end
         ALU_SUB: begin
            wide = {1'b0, x} - {1'b0, y};
            res  = wide[DW-1:0];
            c    = wide[DW];
            v    = (x[DW-1] != y[DW-1]) && (res[DW-1] != x[DW-1]);
         end
         ALU_AND:  res = x & y;
         ALU_OR:   res = x | y;
         ALU_XOR:  res = x ^ y;
         ALU_NOT,
         ALU_NOT2: res = ~x;
         ALU_SHL: begin
            res = {x[DW-2:0], 1'b0};
            c   = x[DW-1];
         end
         ALU_SHR: begin
            res = {1'b0, x[DW-1:1]};
            c   = x[0];
         end
         default: res = '0;
      endcase
      z = (res == '0);
      n = res[DW-1];
   end

endmodule

// File: rtl/datapath_core.sv
// Execute stage: registers A/B, PC and status, operand muxes, ALU and the
// data-memory write port. One decoded instruction commits per clock unless
// stalled. Optional feature macro: DP_MEM_HANDSHAKE_EN (valid/ready write
// handshake that stalls the instruction until the memory accepts).
module datapath_core
   import dp_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input logic clk,
   input logic rst,
   dp_if.slave bus
);

   logic [DW-1:0] reg_a_q;
   logic [DW-1:0] reg_b_q;
   logic [AW-1:0] pc_q;
   logic [3:0]    status_q;
   logic [DW-1:0] op_x;
   logic [DW-1:0] op_y;
   logic [DW-1:0] res;
   dp_flags_t     flags;
   logic          stall;
   logic          commit;

   // Operand X select.
   always_comb begin
      op_x = '0;
      case (bus.selA)
         SELA_A:    op_x = reg_a_q;
         SELA_B:    op_x = reg_b_q;
         SELA_ZERO: op_x = '0;
         SELA_ONE:  op_x = DW'(1);
         default:   op_x = '0;
      endcase
   end

   // Operand Y select.
   always_comb begin
      op_y = '0;
      case (bus.selB)
         SELB_B:    op_y = reg_b_q;
         SELB_A:    op_y = reg_a_q;
         SELB_K:    op_y = bus.K;
         SELB_ZERO: op_y = '0;
         default:   op_y = '0;
      endcase
   end

   dp_alu #(.DW(DW)) u_alu (
      .x   (op_x),
      .y   (op_y),
      .op  (bus.alu_op),
      .res (res),
      .z   (flags.z),
      .n   (flags.n),
      .c   (flags.c),
      .v   (flags.v)
   );

`ifdef DP_MEM_HANDSHAKE_EN
   // A pending write holds the whole instruction until the memory takes it.
   assign stall = bus.W & ~bus.mem_wready;
`else
   logic unused_wready;
   assign unused_wready = bus.mem_wready;
   assign stall         = 1'b0;
`endif

   assign commit = ~stall;

   // Architectural state update; status is frozen on jumps so branches see prior flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_a_q  <= '0;
         reg_b_q  <= '0;
         pc_q     <= '0;
         status_q <= '0;
      end else if (commit) begin
         if (bus.LA) reg_a_q <= res;
         if (bus.LB) reg_b_q <= res;
         if (bus.LP) begin
            pc_q <= bus.K[AW-1:0];
         end else begin
            pc_q     <= pc_q + 1'b1;
            status_q <= flags;
         end
      end
   end

   // Memory port is combinational from the current instruction; forced low while in reset.
   assign bus.mem_wvalid = bus.W & ~rst;
   assign bus.mem_addr   = rst ? '0 : (bus.selData ? bus.K[AW-1:0] : reg_b_q[AW-1:0]);
   assign bus.mem_wdata  = rst ? '0 : res;

   assign bus.pc     = pc_q;
   assign bus.status = status_q;
   assign bus.reg_a  = reg_a_q;
   assign bus.reg_b  = reg_b_q;

endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: directed cases plus random
// instructions compared against an integer-arithmetic reference model.
module tb_datapath_core;
   import dp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errs = 0;
   int   checks = 0;

   int       m_a, m_b, m_pc;
   logic [3:0] m_st;

   dp_if #(.DW(8), .AW(8)) bus ();

   datapath_core #(.DW(8), .AW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed8(input int u);
      return (u > 127) ? u - 256 : u;
   endfunction

   // Reference ALU on plain integers.
   function automatic void m_alu(input int op, input int x, input int y,
                                 output int r, output logic [3:0] f);
      int s;
      int c = 0;
      int v = 0;
      int sx = to_signed8(x);
      int sy = to_signed8(y);
      case (op)
         0: begin s = x + y; r = s % 256; c = int'(s > 255);
                  v = int'((sx + sy > 127) || (sx + sy < -128)); end
         1: begin r = (x - y + 256) % 256; c = int'(x < y);
                  v = int'((sx - sy > 127) || (sx - sy < -128)); end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5, 6: r = 255 - x;
         7: begin r = (x * 2) % 256; c = int'(x >= 128); end
         8: begin r = x / 2; c = x % 2; end
         default: r = 0;
      endcase
      f = {v[0], c[0], r >= 128, r == 0};
   endfunction

   function automatic int pick_x(input logic [1:0] sa);
      case (sa)
         2'b00: return m_a;
         2'b01: return m_b;
         2'b10: return 0;
         default: return 1;
      endcase
   endfunction

   function automatic int pick_y(input logic [1:0] sb, input int k);
      case (sb)
         2'b00: return m_b;
         2'b01: return m_a;
         2'b10: return k;
         default: return 0;
      endcase
   endfunction

   // Present one instruction at a negedge, optionally with hold cycles of wready low.
   task automatic step(input logic la, input logic lb, input logic lp, input logic w,
                       input logic [1:0] sa, input logic [1:0] sb, input logic sd,
                       input logic [3:0] op, input logic [7:0] k, input int hold);
      int r;
      int addr;
      logic [3:0] f;
      bus.LA = la; bus.LB = lb; bus.LP = lp; bus.W = w;
      bus.selA = sa; bus.selB = sb; bus.selData = sd;
      bus.alu_op = op; bus.K = k;
      m_alu(int'(op), pick_x(sa), pick_y(sb, int'(k)), r, f);
      addr = sd ? int'(k) : m_b;
`ifdef DP_MEM_HANDSHAKE_EN
      for (int i = 0; i < hold; i++) begin
         bus.mem_wready = 1'b0;
         #1;
         chk("stall_wvalid", 32'(bus.mem_wvalid), 32'(w));
         @(posedge clk);
         @(negedge clk);
         chk("stall_pc", 32'(bus.pc), m_pc);
         chk("stall_a", 32'(bus.reg_a), m_a);
      end
      bus.mem_wready = 1'b1;
`else
      bus.mem_wready = (hold > 0) ? 1'b0 : 1'($urandom);
`endif
      #1;
      chk("mem_addr", 32'(bus.mem_addr), addr);
      chk("mem_wdata", 32'(bus.mem_wdata), r);
      chk("mem_wvalid", 32'(bus.mem_wvalid), 32'(w));
      @(posedge clk);
      if (la) m_a = r;
      if (lb) m_b = r;
      if (!lp) m_st = f;
      m_pc = lp ? int'(k) : (m_pc + 1) % 256;
      @(negedge clk);
      chk("reg_a", 32'(bus.reg_a), m_a);
      chk("reg_b", 32'(bus.reg_b), m_b);
      chk("pc", 32'(bus.pc), m_pc);
      chk("status", 32'(bus.status), 32'(m_st));
   endtask

   initial begin
      bus.LA = 1'b0; bus.LB = 1'b0; bus.LP = 1'b0; bus.W = 1'b1;
      bus.selA = 2'b00; bus.selB = 2'b10; bus.selData = 1'b1;
      bus.alu_op = ALU_ADD; bus.K = 8'h5A; bus.mem_wready = 1'b1;
      #1 rst = 1'b1;
      m_a = 0; m_b = 0; m_pc = 0; m_st = 4'h0;
      @(negedge clk); @(negedge clk);
      chk("rst_pc", 32'(bus.pc), 0);
      chk("rst_status", 32'(bus.status), 0);
      chk("rst_a", 32'(bus.reg_a), 0);
      chk("rst_b", 32'(bus.reg_b), 0);
      chk("rst_wvalid", 32'(bus.mem_wvalid), 0);
      chk("rst_addr", 32'(bus.mem_addr), 0);
      chk("rst_wdata", 32'(bus.mem_wdata), 0);
      rst = 1'b0;

      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 0, 0, 2'b00, 2'b00, 0, ALU_ADD, 8'h00, 0);
         chk("idle_pc", 32'(bus.pc), i);
      end
      chk("idle_status", 32'(bus.status), 32'h1);

      step(1, 0, 0, 0, 2'b10, 2'b10, 0, ALU_ADD, 8'h05, 0);
      chk("add_a05", 32'(bus.reg_a), 32'h05);
      step(1, 0, 0, 0, 2'b00, 2'b10, 0, ALU_ADD, 8'hFB, 0);
      chk("add_wrap_a", 32'(bus.reg_a), 32'h00);
      chk("add_wrap_st", 32'(bus.status), 32'h5);

      step(1, 0, 0, 0, 2'b10, 2'b10, 0, ALU_ADD, 8'h7F, 0);
      step(1, 0, 0, 0, 2'b00, 2'b10, 0, ALU_ADD, 8'h01, 0);
      chk("ovf_a", 32'(bus.reg_a), 32'h80);
      chk("ovf_st", 32'(bus.status), 32'hA);

      step(1, 0, 0, 0, 2'b10, 2'b10, 0, ALU_ADD, 8'h03, 0);
      step(0, 1, 0, 0, 2'b10, 2'b10, 0, ALU_ADD, 8'h05, 0);
      step(1, 0, 0, 0, 2'b00, 2'b00, 0, ALU_SUB, 8'h00, 0);
      chk("sub_a", 32'(bus.reg_a), 32'hFE);
      chk("sub_st", 32'(bus.status), 32'h6);
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, ALU_ADD, 8'h20, 0);
      chk("jmp_pc", 32'(bus.pc), 32'h20);
      chk("jmp_st", 32'(bus.status), 32'h6);

      step(1, 0, 0, 0, 2'b10, 2'b10, 0, ALU_ADD, 8'h81, 0);
      step(0, 1, 0, 0, 2'b00, 2'b00, 0, ALU_SHL, 8'h00, 0);
      chk("shl_b", 32'(bus.reg_b), 32'h02);
      chk("shl_c", 32'(bus.status[ST_C]), 1);
      step(0, 1, 0, 0, 2'b01, 2'b00, 0, ALU_SHR, 8'h00, 0);
      chk("shr_b", 32'(bus.reg_b), 32'h01);
      chk("shr_c", 32'(bus.status[ST_C]), 0);

      step(0, 0, 1, 0, 2'b00, 2'b00, 0, ALU_ADD, 8'hFE, 0);
      step(0, 0, 0, 0, 2'b00, 2'b00, 0, 4'hF, 8'h00, 0);
      chk("pc_wrap_ff", 32'(bus.pc), 32'hFF);
      step(0, 0, 0, 0, 2'b00, 2'b00, 0, 4'hF, 8'h00, 0);
      chk("pc_wrap_00", 32'(bus.pc), 32'h00);

`ifdef DP_MEM_HANDSHAKE_EN
      step(0, 0, 0, 1, 2'b10, 2'b10, 1, ALU_ADD, 8'h40, 3);
      bus.W = 1'b1; bus.selData = 1'b1; bus.K = 8'h40; bus.mem_wready = 1'b0;
      #1;
      chk("hs_pre_rst_wvalid", 32'(bus.mem_wvalid), 1);
      rst = 1'b1;
      #1;
      chk("hs_rst_wvalid", 32'(bus.mem_wvalid), 0);
      chk("hs_rst_pc", 32'(bus.pc), 0);
      m_a = 0; m_b = 0; m_pc = 0; m_st = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      bus.mem_wready = 1'b1;
`endif

      for (int n = 0; n < 400; n++) begin
         logic w;
         w = 1'($urandom);
         step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0), w,
              2'($urandom), 2'($urandom), 1'($urandom),
              4'($urandom_range(0, 15)), 8'($urandom),
              w ? $urandom_range(0, 2) : 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
